bank_sram_butterfly_read_if: RTL and testbench

//  Read-side counterpart of the bank-SRAM butterfly write interface. Issues one row read to all NBANK banks.

---
 rtl/bank_sram_butterfly_read_if_pkg.sv | 26 ++
 rtl/bank_sram_butterfly_read_perm.sv | 47 ++++
 rtl/bank_sram_butterfly_read_if.sv | 122 ++++++++++++
 tb/tb_bank_sram_butterfly_read_if.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_sram_butterfly_read_if_pkg.sv
// Shared bank-butterfly configuration: bank geometry, selector widths and lane helpers.
// Used by the read interface and its inverse permutation network.
package bank_sram_butterfly_read_if_pkg;
  localparam int BW           = 8;
  localparam int NDATA        = 32;
  localparam int NBANK        = 16;
  localparam int CLOG2_NBANK  = $clog2(NBANK);
  localparam int CCLOG2_NBANK = $clog2(CLOG2_NBANK);
  localparam int HIADDR_W     = $clog2(NDATA);
  // Lane address is {1'b0, hiaddr, lane}; each xor_src entry selects one of its bits.
  localparam int LADDR_W      = 1 + HIADDR_W + CLOG2_NBANK;
  localparam int XOR_BW       = $clog2(LADDR_W);
  localparam int XOR_SRC_W    = XOR_BW * CLOG2_NBANK;
  localparam int DATA_W       = BW * NBANK;

  typedef struct packed {
    logic                    vld;
    logic [XOR_SRC_W-1:0]    xor_src;
    logic [CCLOG2_NBANK-1:0] xor_swap;
    logic [HIADDR_W-1:0]     hiaddr;
  } rd_cfg_t;

  function automatic int unsigned lane_rotl(input int unsigned j, input int unsigned s);
    return ((j << s) | (j >> (CLOG2_NBANK - s))) & (NBANK - 1);
  endfunction
endpackage

// File: rtl/bank_sram_butterfly_read_perm.sv
// Combinational inverse of the write-side butterfly: omega stages high-to-low, then
// butterfly stages high-to-low, so lane k returns to the position it had on write.
module bank_sram_butterfly_read_perm
  import bank_sram_butterfly_read_if_pkg::*;
(
  input  logic [XOR_SRC_W-1:0]    i_xor_src,
  input  logic [CCLOG2_NBANK-1:0] i_xor_swap,
  input  logic [HIADDR_W-1:0]     i_hiaddr,
  input  logic [DATA_W-1:0]       i_data,
  output logic [DATA_W-1:0]       o_data
);
  logic [NBANK-1:0][BW-1:0]  cur;
  logic [NBANK-1:0][BW-1:0]  nxt;
  logic [XOR_BW-1:0]         sel;
  logic [(2**XOR_BW)-1:0]    addr;
  logic [CLOG2_NBANK-1:0]    src_lane;

  always_comb begin
    cur      = i_data;
    nxt      = '0;
    sel      = '0;
    addr     = '0;
    src_lane = '0;
    for (int i = CCLOG2_NBANK - 1; i >= 0; i--) begin
      nxt = cur;
      if (i_xor_swap[i]) begin
        for (int j = 0; j < NBANK; j++) begin
          src_lane = CLOG2_NBANK'(lane_rotl(j, 1 << i));
          nxt[j]   = cur[src_lane];
        end
      end
      cur = nxt;
    end
    // Address is zero-extended to the full selector range so out-of-range selectors read 0.
    for (int i = CLOG2_NBANK - 1; i >= 0; i--) begin
      sel = i_xor_src[i*XOR_BW +: XOR_BW];
      for (int j = 0; j < NBANK; j++) begin
        addr                 = '0;
        addr[LADDR_W-2:0]    = {i_hiaddr, CLOG2_NBANK'(j)};
        src_lane             = CLOG2_NBANK'(j ^ (1 << i));
        nxt[j]               = addr[sel] ? cur[src_lane] : cur[j];
      end
      cur = nxt;
    end
    o_data = cur;
  end
endmodule

// File: rtl/bank_sram_butterfly_read_if.sv
// Bank-SRAM butterfly read interface: credit-gated row reads, config carried alongside
// SRAM latency, inverse permutation, output FIFO. Option: BANK_SRAM_READ_OUTREG_EN.
module bank_sram_butterfly_read_if
  import bank_sram_butterfly_read_if_pkg::*;
#(
  parameter int SRAM_LAT   = 1,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_rdy,
  output logic                    o_ack,
  input  logic [XOR_SRC_W-1:0]    i_xor_src,
  input  logic [CCLOG2_NBANK-1:0] i_xor_swap,
  input  logic [HIADDR_W-1:0]     i_hiaddr,
  output logic                    o_sram_ce,
  output logic [HIADDR_W-1:0]     o_sram_raddr,
  input  logic [DATA_W-1:0]       i_sram_rdata,
  output logic                    o_rdy,
  input  logic                    i_ack,
  output logic [DATA_W-1:0]       o_data
);
  localparam int CW = $clog2(OBUF_DEPTH + 1) + 1;
  localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;

  // Handshake: a beat moves when valid (i_rdy / o_rdy) and ready (o_ack / i_ack) are both high.
  rd_cfg_t [SRAM_LAT-1:0] cfg_pipe;
  rd_cfg_t                cfg_tail;
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          fifo_cnt;
  logic [DATA_W-1:0]      perm_data;
  logic [DATA_W-1:0]      push_data;
  logic                   push;
  logic                   pop;
  logic [DATA_W-1:0]      fifo_mem [OBUF_DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_ack        = i_rdy && ((inflight + fifo_cnt) < CW'(OBUF_DEPTH));
  assign o_sram_ce    = o_ack;
  assign o_sram_raddr = o_ack ? i_hiaddr : '0;
  assign cfg_tail     = cfg_pipe[SRAM_LAT-1];
  assign o_rdy        = (fifo_cnt != '0);
  assign o_data       = fifo_mem[rd_ptr];
  assign pop          = o_rdy && i_ack;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cfg_pipe <= '0;
    end else begin
      cfg_pipe[0] <= '{vld: o_ack, xor_src: i_xor_src, xor_swap: i_xor_swap, hiaddr: i_hiaddr};
      for (int k = 1; k < SRAM_LAT; k++) cfg_pipe[k] <= cfg_pipe[k-1];
    end
  end

  bank_sram_butterfly_read_perm u_perm (
    .i_xor_src  (cfg_tail.xor_src),
    .i_xor_swap (cfg_tail.xor_swap),
    .i_hiaddr   (cfg_tail.hiaddr),
    .i_data     (i_sram_rdata),
    .o_data     (perm_data)
  );

`ifdef BANK_SRAM_READ_OUTREG_EN
  logic              out_vld;
  logic [DATA_W-1:0] out_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      out_vld <= 1'b0;
      out_q   <= '0;
    end else begin
      out_vld <= cfg_tail.vld;
      out_q   <= perm_data;
    end
  end

  assign push      = out_vld;
  assign push_data = out_q;
`else
  assign push      = cfg_tail.vld;
  assign push_data = perm_data;
`endif

  // A read stays in flight until it lands in the FIFO, so any output register is covered.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      inflight <= '0;
    end else begin
      case ({o_ack, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int k = 0; k < OBUF_DEPTH; k++) fifo_mem[k] <= '0;
    end else begin
      assert (!(push && (fifo_cnt == CW'(OBUF_DEPTH)) && !pop));
      if (push) begin
        fifo_mem[wr_ptr] <= push_data;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_bank_sram_butterfly_read_if.sv
// Directed bench for bank_sram_butterfly_read_if: write-side model feeds an SRAM model,
// a scoreboard queue checks every output beat in order.
module tb_bank_sram_butterfly_read_if;
  import bank_sram_butterfly_read_if_pkg::*;

  localparam int SRAM_LAT   = 1;
  localparam int OBUF_DEPTH = 4;
`ifdef BANK_SRAM_READ_OUTREG_EN
  localparam int EXP_LAT = SRAM_LAT + 2;
`else
  localparam int EXP_LAT = SRAM_LAT + 1;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic                    i_rdy = 1'b0;
  logic                    i_ack = 1'b0;
  logic [XOR_SRC_W-1:0]    i_xor_src = '0;
  logic [CCLOG2_NBANK-1:0] i_xor_swap = '0;
  logic [HIADDR_W-1:0]     i_hiaddr = '0;
  logic [DATA_W-1:0]       i_sram_rdata;
  logic                    o_ack, o_sram_ce, o_rdy;
  logic [HIADDR_W-1:0]     o_sram_raddr;
  logic [DATA_W-1:0]       o_data;

  bank_sram_butterfly_read_if #(.SRAM_LAT(SRAM_LAT), .OBUF_DEPTH(OBUF_DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_rdy        (i_rdy),
    .o_ack        (o_ack),
    .i_xor_src    (i_xor_src),
    .i_xor_swap   (i_xor_swap),
    .i_hiaddr     (i_hiaddr),
    .o_sram_ce    (o_sram_ce),
    .o_sram_raddr (o_sram_raddr),
    .i_sram_rdata (i_sram_rdata),
    .o_rdy        (o_rdy),
    .i_ack        (i_ack),
    .o_data       (o_data)
  );

  // SRAM model: read captured on the ce edge, then delayed to SRAM_LAT total
  logic [DATA_W-1:0] mem [NDATA];
  logic [DATA_W-1:0] rd_pipe [SRAM_LAT];
  always @(posedge clk) begin
    if (o_sram_ce) rd_pipe[0] <= mem[o_sram_raddr];
    for (int k = 1; k < SRAM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign i_sram_rdata = rd_pipe[SRAM_LAT-1];

  // scoreboard
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_v;
  int tests_run = 0;
  int fails = 0;
  int n_pop = 0;
  int first_pop = 0;
  int last_pop = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write-side model: butterfly stages low-to-high, then omega rotations applied forward.
  function automatic logic [DATA_W-1:0] wr_perm(input logic [DATA_W-1:0] d,
                                                input logic [XOR_SRC_W-1:0] xs,
                                                input logic [CCLOG2_NBANK-1:0] sw,
                                                input logic [HIADDR_W-1:0] ha);
    logic [NBANK-1:0][BW-1:0] c, n;
    int unsigned s, a, r, dst;
    c = d;
    for (int i = 0; i < CLOG2_NBANK; i++) begin
      s = xs[i*XOR_BW +: XOR_BW];
      for (int j = 0; j < NBANK; j++) begin
        a = (int'(ha) << CLOG2_NBANK) | j;
        n[j] = (s < LADDR_W && ((a >> s) & 1) == 1) ? c[j ^ (1 << i)] : c[j];
      end
      c = n;
    end
    for (int i = 0; i < CCLOG2_NBANK; i++) begin
      if (sw[i]) begin
        r = 1 << i;
        for (int j = 0; j < NBANK; j++) begin
          dst = ((j << r) | (j >> (CLOG2_NBANK - r))) % NBANK;
          n[dst] = c[j];
        end
        c = n;
      end
    end
    return c;
  endfunction

  task automatic rand_vec(output logic [XOR_SRC_W-1:0] xs, output logic [CCLOG2_NBANK-1:0] sw,
                          output logic [HIADDR_W-1:0] ha, output logic [DATA_W-1:0] d);
    int unsigned v;
    for (int i = 0; i < CLOG2_NBANK; i++) begin
      v = $urandom_range(0, LADDR_W - 2);
      if (v >= i) v++;
      xs[i*XOR_BW +: XOR_BW] = XOR_BW'(v);
    end
    sw = CCLOG2_NBANK'($urandom_range(0, (1 << CCLOG2_NBANK) - 1));
    ha = HIADDR_W'($urandom_range(0, NDATA - 1));
    d  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // driver: one cycle of request/accept; ends at posedge+1 with i_rdy idle
  task automatic drive(input logic rdy, input logic ack, input logic [XOR_SRC_W-1:0] xs,
                       input logic [CCLOG2_NBANK-1:0] sw, input logic [HIADDR_W-1:0] ha,
                       input logic [DATA_W-1:0] d, output logic acc);
    i_rdy = rdy; i_ack = ack; i_xor_src = xs; i_xor_swap = sw; i_hiaddr = ha;
    if (rdy) mem[ha] = wr_perm(d, xs, sw, ha);
    @(negedge clk);
    acc = o_ack;
    if (acc) exp_q.push_back(d);
    @(posedge clk); #1;
    i_rdy = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int c = 0;
    i_ack = 1'b1;
    while (exp_q.size() != 0 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  // monitor: pop and compare every transferred beat
  always @(negedge clk) begin
    if (rst_n && o_rdy && i_ack) begin
      chk("queue_nonempty", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        chk("data", o_data, exp_v);
      end
      n_pop++;
      if (n_pop == 1) first_pop = cyc;
      last_pop = cyc;
    end
  end

  initial begin
    logic [XOR_SRC_W-1:0]    xs;
    logic [CCLOG2_NBANK-1:0] sw;
    logic [HIADDR_W-1:0]     ha;
    logic [DATA_W-1:0]       d;
    logic                    acc;
    int                      acc_n, lat, nrt;

    for (int r = 0; r < NDATA; r++) mem[r] = '0;
    #2;
    chk("rst_o_rdy", o_rdy, 0);
    chk("rst_sram_ce", o_sram_ce, 0);
    chk("rst_sram_raddr", o_sram_raddr, 0);
    chk("rst_o_data", o_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1 identity, latency
    for (int i = 0; i < CLOG2_NBANK; i++) xs[i*XOR_BW +: XOR_BW] = XOR_BW'(LADDR_W - 1);
    for (int k = 0; k < NBANK; k++) d[k*BW +: BW] = BW'(k);
    drive(1'b1, 1'b1, xs, '0, HIADDR_W'(5), d, acc);
    chk("id_accept", acc, 1);
    lat = 1;
    while (!o_rdy && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("id_latency", lat, EXP_LAT);
    wait_drain("id_drain");

    // 2 round trip
    nrt = 0;
    for (int c = 0; c < 1300 && nrt < 1000; c++) begin
      rand_vec(xs, sw, ha, d);
      drive(1'b1, 1'b1, xs, sw, ha, d, acc);
      if (acc) nrt++;
    end
    chk("rt_count", nrt, 1000);
    wait_drain("rt_drain");

    // 3 back-pressure
    acc_n = 0;
    for (int c = 0; c < 10; c++) begin
      rand_vec(xs, sw, ha, d);
      drive(1'b1, 1'b0, xs, sw, ha, d, acc);
      if (acc) acc_n++;
    end
    chk("bp_accepts", acc_n, OBUF_DEPTH);
    i_rdy = 1'b1; #1;
    chk("bp_ack_low", o_ack, 0);
    i_rdy = 1'b0;
    n_pop = 0;
    wait_drain("bp_drain");
    chk("bp_outputs", n_pop, OBUF_DEPTH);
    rand_vec(xs, sw, ha, d);
    drive(1'b1, 1'b1, xs, sw, ha, d, acc);
    chk("bp_ack_back", acc, 1);
    wait_drain("bp_drain2");

    // 4 full throughput
    n_pop = 0; acc_n = 0;
    for (int c = 0; c < 20; c++) begin
      rand_vec(xs, sw, ha, d);
      drive(1'b1, 1'b1, xs, sw, ha, d, acc);
      if (acc) acc_n++;
    end
    chk("ft_accepts", acc_n, 20);
    wait_drain("ft_drain");
    chk("ft_outputs", n_pop, 20);
    chk("ft_no_bubble", last_pop - first_pop, 19);

    // 5 push/pop at the credit limit with random back-pressure
    for (int c = 0; c < 60; c++) begin
      rand_vec(xs, sw, ha, d);
      drive(1'b1, 1'($urandom_range(0, 1)), xs, sw, ha, d, acc);
    end
    wait_drain("pp_drain");

    // 6 reset with two reads in flight
    acc_n = 0;
    for (int c = 0; c < 2; c++) begin
      rand_vec(xs, sw, ha, d);
      drive(1'b1, 1'b0, xs, sw, ha, d, acc);
      if (acc) acc_n++;
    end
    chk("rs_accepts", acc_n, 2);
    rst_n = 1'b0;
    #1;
    chk("rs_o_rdy", o_rdy, 0);
    chk("rs_sram_ce", o_sram_ce, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n_pop = 0;
    for (int c = 0; c < 5; c++) drive(1'b0, 1'b1, '0, '0, '0, '0, acc);
    chk("rs_no_late", n_pop, 0);
    chk("rs_o_rdy_idle", o_rdy, 0);
    acc_n = 0;
    for (int c = 0; c < 6; c++) begin
      rand_vec(xs, sw, ha, d);
      drive(1'b1, 1'b0, xs, sw, ha, d, acc);
      if (acc) acc_n++;
    end
    chk("rs_credits", acc_n, OBUF_DEPTH);
    wait_drain("rs_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
